// File: rtl/score_display_ctrl.sv
// Score display sequencer: iterative double-dabble binary->BCD conversion,
// four-digit seven-segment scan, and the game-over message cycle.
module score_display_ctrl #(
  parameter int SCAN_DIV  = 50000,
  parameter int BLINK_DIV = 25000000,
  parameter int SCORE_W   = 11
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               game_state,
  input  logic [SCORE_W-1:0] score,
  input  logic               score_valid,
  output logic               busy,
  output logic [15:0]        bcd_out,
  output logic [3:0]         Anode_Activate,
  output logic [6:0]         LED_out
);

  localparam int SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_Y     = 7'b1000100;
  localparam logic [6:0] SEG_O     = 7'b0000001;
  localparam logic [6:0] SEG_U     = 7'b1000001;
  localparam logic [6:0] SEG_L     = 7'b1110001;
  localparam logic [6:0] SEG_S     = 7'b0100100;
  localparam logic [6:0] SEG_E     = 7'b0110000;

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  state_t             state, state_nx;
  logic [SCORE_W-1:0] shreg, shreg_nx;
  logic [SCORE_W-1:0] pend_score, pend_score_nx;
  logic               pending, pending_nx;
  logic [15:0]        scratch, scratch_nx, adj;
  logic [15:0]        bcd_nx;
  logic [3:0]         bit_cnt, bit_cnt_nx;

  logic [SCAN_W-1:0]  scan_cnt;
  logic [1:0]         idx;
  logic [BLINK_W-1:0] blink_cnt;
  logic [3:0]         phase;
  logic               gs_q;
  logic [3:0]         nib;
  logic [6:0]         seg_nx;
  logic [3:0]         anode_nx;

  // Add 3 to every nibble >= 5 ahead of the shift (double-dabble correction)
  function automatic logic [15:0] dabble(input logic [15:0] s);
    logic [15:0] r;
    r = s;
    for (int i = 0; i < 4; i++)
      if (s[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = s[i*4 +: 4] + 4'd3;
    return r;
  endfunction

  function automatic logic [6:0] digit_seg(input logic [3:0] d);
    case (d)
      4'd1:    digit_seg = 7'b1001111;
      4'd2:    digit_seg = 7'b0010010;
      4'd3:    digit_seg = 7'b0000110;
      4'd4:    digit_seg = 7'b1001100;
      4'd5:    digit_seg = 7'b0100100;
      4'd6:    digit_seg = 7'b0100000;
      4'd7:    digit_seg = 7'b0001111;
      4'd8:    digit_seg = 7'b0000000;
      4'd9:    digit_seg = 7'b0000100;
      default: digit_seg = 7'b0000001;  // 0, and any non-BCD nibble
    endcase
  endfunction

  assign busy = (state != IDLE);
  assign adj  = dabble(scratch);

  // Conversion FSM next-state; a request arriving at COMMIT or parked in
  // pending restarts SHIFT directly so busy never drops between results
  always_comb begin
    state_nx      = state;
    shreg_nx      = shreg;
    scratch_nx    = scratch;
    bit_cnt_nx    = bit_cnt;
    pending_nx    = pending;
    pend_score_nx = pend_score;
    bcd_nx        = bcd_out;
    case (state)
      IDLE: if (score_valid) begin
        shreg_nx   = score;
        scratch_nx = '0;
        bit_cnt_nx = 4'(SCORE_W);
        state_nx   = SHIFT;
      end
      SHIFT: begin
        scratch_nx = {adj[14:0], shreg[SCORE_W-1]};
        shreg_nx   = {shreg[SCORE_W-2:0], 1'b0};
        bit_cnt_nx = bit_cnt - 4'd1;
        if (bit_cnt == 4'd1) state_nx = COMMIT;
        if (score_valid) begin
          pending_nx    = 1'b1;
          pend_score_nx = score;
        end
      end
      COMMIT: begin
        bcd_nx     = scratch;
        pending_nx = 1'b0;
        if (score_valid || pending) begin
          shreg_nx   = score_valid ? score : pend_score;
          scratch_nx = '0;
          bit_cnt_nx = 4'(SCORE_W);
          state_nx   = SHIFT;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Conversion state registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      shreg      <= '0;
      pend_score <= '0;
      pending    <= 1'b0;
      scratch    <= '0;
      bit_cnt    <= '0;
      bcd_out    <= '0;
    end else begin
      state      <= state_nx;
      shreg      <= shreg_nx;
      pend_score <= pend_score_nx;
      pending    <= pending_nx;
      scratch    <= scratch_nx;
      bit_cnt    <= bit_cnt_nx;
      bcd_out    <= bcd_nx;
    end
  end

  // Digit scan prescaler and slot index
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      idx      <= '0;
    end else if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
      scan_cnt <= '0;
      idx      <= idx + 2'd1;
    end else begin
      scan_cnt <= scan_cnt + SCAN_W'(1);
    end
  end

  // Message phase; held at 0 while playing and restarted on the falling edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gs_q      <= 1'b0;
      blink_cnt <= '0;
      phase     <= '0;
    end else begin
      gs_q <= game_state;
      if (game_state || gs_q) begin
        blink_cnt <= '0;
        phase     <= '0;
      end else if (blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
        blink_cnt <= '0;
        phase     <= (phase == 4'd8) ? 4'd0 : phase + 4'd1;
      end else begin
        blink_cnt <= blink_cnt + BLINK_W'(1);
      end
    end
  end

  // Glyph select for the current slot: score digit or message letter
  always_comb begin
    nib      = bcd_out[{~idx, 2'b00} +: 4];
    anode_nx = ~(4'b1000 >> idx);
    seg_nx   = SEG_BLANK;
    if (game_state) begin
      seg_nx = digit_seg(nib);
    end else begin
      case (phase)
        4'd0: case (idx)
          2'd0: seg_nx = SEG_BLANK;
          2'd1: seg_nx = SEG_Y;
          2'd2: seg_nx = SEG_O;
          default: seg_nx = SEG_U;
        endcase
        4'd2: case (idx)
          2'd0: seg_nx = SEG_L;
          2'd1: seg_nx = SEG_O;
          2'd2: seg_nx = SEG_S;
          default: seg_nx = SEG_E;
        endcase
        4'd4, 4'd5, 4'd6, 4'd7: seg_nx = digit_seg(nib);
        default: seg_nx = SEG_BLANK;
      endcase
    end
  end

  // Registered pin drive; anode and segments change on the same edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      Anode_Activate <= 4'b1111;
      LED_out        <= SEG_BLANK;
    end else begin
      Anode_Activate <= anode_nx;
      LED_out        <= seg_nx;
    end
  end

endmodule
